// File: rtl/reg_serial_out_pkg.sv
// Shared types and defaults for the serial read-out register.
// Holds the FSM encoding, the shift-direction encoding, the control bundle
// driven into the shift register, and a helper that picks the outgoing bit
// position for a given bit order.
package reg_serial_out_pkg;

    // Default word geometry; CNT_W must equal clog2(WIDTH).
    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 5;

    // Two-state controller: waiting for a word, or streaming one out.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Direction in which the register moves its contents on a shift.
    // SHIFT_TO_LSB presents bit 0 first; SHIFT_TO_MSB presents bit WIDTH-1 first.
    typedef enum logic {
        SHIFT_TO_LSB = 1'b0,
        SHIFT_TO_MSB = 1'b1
    } shift_dir_t;

    // Per-cycle command to the shift register. Priority is clear > load > shift.
    typedef struct packed {
        logic clear;
        logic load;
        logic shift;
    } shreg_ctrl_t;

    // Idle command: the register holds its contents.
    localparam shreg_ctrl_t SHREG_HOLD = '{clear: 1'b0, load: 1'b0, shift: 1'b0};

    // Direction implied by the bit-order parameter of the top level.
    function automatic shift_dir_t dir_from_order(input bit msb_first);
        return msb_first ? SHIFT_TO_MSB : SHIFT_TO_LSB;
    endfunction

endpackage : reg_serial_out_pkg

// File: rtl/reg_serial_out_shift_register.sv
// WIDTH-bit register with parallel load, shift enable, shift direction and
// synchronous clear. Built as an array of identical one-bit cells, each
// selecting its next value from clear / load / neighbour / hold.
// Only the bit at the output end of the shift is exported.
module reg_serial_out_shift_register
    import reg_serial_out_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  shreg_ctrl_t      ctrl,
    input  shift_dir_t       dir,
    input  logic [WIDTH-1:0] data_in,
    output logic             head
);

    // Current register contents, gathered from the individual cells.
    logic [WIDTH-1:0] q;
    // Value each cell takes when a shift is commanded.
    logic [WIDTH-1:0] shifted;

    // Neighbour selection: move one place toward the output end, fill with 0.
    always_comb begin
        shifted = '0;
        if (dir == SHIFT_TO_LSB) begin
            shifted = {1'b0, q[WIDTH-1:1]};
        end else begin
            shifted = {q[WIDTH-2:0], 1'b0};
        end
    end

    // One flip-flop cell per bit; each owns its own storage element.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic bit_q;

        // Cell update: clear wins over load, load wins over shift, else hold.
        always_ff @(posedge clk) begin
            // NOTE: state is written with <= so every cell samples its
            // neighbour's old value; with = the shift would ripple in one edge.
            if (ctrl.clear) begin
                bit_q <= 1'b0;
            end else if (ctrl.load) begin
                bit_q <= data_in[i];
            end else if (ctrl.shift) begin
                bit_q <= shifted[i];
            end
        end

        assign q[i] = bit_q;
    end : g_cell

    // The bit presented to the serial sink sits at the end the data moves toward.
    assign head = (dir == SHIFT_TO_LSB) ? q[0] : q[WIDTH-1];

endmodule : reg_serial_out_shift_register

// File: rtl/reg_serial_out.sv
// Serializer: accepts one WIDTH-bit word on a valid/ready load port and emits
// it one bit per beat on a valid/ready serial stream with a last-bit flag.
// Holds the IDLE/SHIFT controller, the beat counter and the output decode.
// Outputs are decoded from registered state only; no input reaches an output
// combinationally.
module reg_serial_out
    import reg_serial_out_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CNT_W     = DEF_CNT_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_ready,
    output logic             ser_valid,
    output logic             ser_out,
    output logic             ser_last,
    output logic             busy
);

    // Counter value on the final beat of a word.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    // Shift direction fixed by the bit order.
    localparam shift_dir_t DIR = dir_from_order(MSB_FIRST);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    shreg_ctrl_t      sr_ctrl;
    logic             sr_head;
    logic             on_last;

    // The counter reaching LAST_CNT marks the final bit of the word.
    assign on_last = (cnt_q == LAST_CNT);

    // Data path: the word is held and moved by the shift register.
    reg_serial_out_shift_register #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk     (clk),
        .ctrl    (sr_ctrl),
        .dir     (DIR),
        .data_in (data_in),
        .head    (sr_head)
    );

    // State and beat-counter registers; clr returns both to their idle values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter, shift-register command and output decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_ctrl    = SHREG_HOLD;
        load_ready = 1'b0;
        ser_valid  = 1'b0;
        ser_out    = 1'b0;
        ser_last   = 1'b0;
        busy       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    // Capture the word; data_in is not looked at again.
                    sr_ctrl.load = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                ser_valid = 1'b1;
                busy      = 1'b1;
                ser_out   = sr_head;
                ser_last  = on_last;
                if (ser_ready) begin
                    if (on_last) begin
                        // Final beat: leave nothing behind for the next word.
                        sr_ctrl.clear = 1'b1;
                        cnt_d         = '0;
                        state_d       = ST_IDLE;
                    end else begin
                        sr_ctrl.shift = 1'b1;
                        cnt_d         = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // clr overrides everything: abort any word and empty the register.
        if (clr) begin
            sr_ctrl = '{clear: 1'b1, load: 1'b0, shift: 1'b0};
        end
    end

endmodule : reg_serial_out

// File: tb/tb_reg_serial_out.sv
// Self-checking bench for reg_serial_out. Two instances share all inputs:
// one sends LSB first, the other MSB first. The expected stream of every
// word is derived from the word itself (bit k, or bit WIDTH-1-k, on beat k),
// with the beat index advancing only on cycles where ser_ready was high.
module tb_reg_serial_out;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clr;
    logic         load_valid;
    logic [W-1:0] data_in;
    logic         ser_ready;

    logic l_load_ready, l_ser_valid, l_ser_out, l_ser_last, l_busy;
    logic m_load_ready, m_ser_valid, m_ser_out, m_ser_last, m_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_serial_out #(.WIDTH(W), .CNT_W(5), .MSB_FIRST(1'b0)) u_lsb (
        .clk        (clk),
        .clr        (clr),
        .load_valid (load_valid),
        .load_ready (l_load_ready),
        .data_in    (data_in),
        .ser_ready  (ser_ready),
        .ser_valid  (l_ser_valid),
        .ser_out    (l_ser_out),
        .ser_last   (l_ser_last),
        .busy       (l_busy)
    );

    reg_serial_out #(.WIDTH(W), .CNT_W(5), .MSB_FIRST(1'b1)) u_msb (
        .clk        (clk),
        .clr        (clr),
        .load_valid (load_valid),
        .load_ready (m_load_ready),
        .data_in    (data_in),
        .ser_ready  (ser_ready),
        .ser_valid  (m_ser_valid),
        .ser_out    (m_ser_out),
        .ser_last   (m_ser_last),
        .busy       (m_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are looked at 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_l_load_ready"}, 32'(l_load_ready), 32'd1);
        check({tag, "_l_busy"},       32'(l_busy),       32'd0);
        check({tag, "_l_ser_valid"},  32'(l_ser_valid),  32'd0);
        check({tag, "_l_ser_out"},    32'(l_ser_out),    32'd0);
        check({tag, "_l_ser_last"},   32'(l_ser_last),   32'd0);
        check({tag, "_m_load_ready"}, 32'(m_load_ready), 32'd1);
        check({tag, "_m_busy"},       32'(m_busy),       32'd0);
        check({tag, "_m_ser_valid"},  32'(m_ser_valid),  32'd0);
        check({tag, "_m_ser_out"},    32'(m_ser_out),    32'd0);
        check({tag, "_m_ser_last"},   32'(m_ser_last),   32'd0);
    endtask

    // Beat k of word w: LSB-first sends w[k], MSB-first sends w[W-1-k].
    task automatic check_bit(input string tag, input logic [W-1:0] w, input int k);
        logic exp_l;
        logic exp_m;
        logic exp_last;
        exp_l    = w[k];
        exp_m    = w[W-1-k];
        exp_last = (k == W - 1);
        check($sformatf("%s_b%0d_l_ser_out", tag, k),   32'(l_ser_out),    32'(exp_l));
        check($sformatf("%s_b%0d_m_ser_out", tag, k),   32'(m_ser_out),    32'(exp_m));
        check($sformatf("%s_b%0d_l_ser_last", tag, k),  32'(l_ser_last),   32'(exp_last));
        check($sformatf("%s_b%0d_m_ser_last", tag, k),  32'(m_ser_last),   32'(exp_last));
        check($sformatf("%s_b%0d_l_valid", tag, k),     32'(l_ser_valid),  32'd1);
        check($sformatf("%s_b%0d_m_valid", tag, k),     32'(m_ser_valid),  32'd1);
        check($sformatf("%s_b%0d_l_load_ready", tag, k), 32'(l_load_ready), 32'd0);
        check($sformatf("%s_b%0d_m_busy", tag, k),      32'(m_busy),       32'd1);
    endtask

    // Load word w and follow it to completion (or abort).
    //  rand_ready : ser_ready random per cycle instead of held high
    //  stall_beat : beat index at which ser_ready is held low stall_len cycles
    //  abort_beat : beat index at which clr is pulsed (-1: none)
    //  wiggle     : keep load_valid high and scramble data_in while shifting
    task automatic send_word(input logic [W-1:0] w, input bit rand_ready,
                             input int stall_beat, input int stall_len,
                             input int abort_beat, input bit wiggle, input string tag);
        int k      = 0;
        int stalls = 0;
        int cycles = 0;
        bit rdy;
        check_idle({tag, "_pre"});
        load_valid = 1'b1;
        data_in    = w;
        tick();
        if (!wiggle) begin
            load_valid = 1'b0;
            data_in    = $urandom;
        end
        while (k < W) begin
            if (k == abort_beat) begin
                clr = 1'b1;
                tick();
                clr        = 1'b0;
                load_valid = 1'b0;
                check_idle({tag, "_abort"});
                tick();
                check_idle({tag, "_abort_hold"});
                ser_ready = 1'b1;
                return;
            end
            if (cycles > 400) begin
                check({tag, "_timeout_beats"}, 32'(k), 32'(W));
                load_valid = 1'b0;
                return;
            end
            if (k == stall_beat && stalls < stall_len) begin
                rdy = 1'b0;
                stalls++;
            end else if (rand_ready) begin
                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b1;
            end
            check_bit(tag, w, k);
            if (wiggle) begin
                load_valid = 1'b1;
                data_in    = $urandom;
            end
            ser_ready = rdy;
            tick();
            cycles++;
            if (rdy) k++;
        end
        load_valid = 1'b0;
        ser_ready  = 1'b1;
        check_idle({tag, "_done"});
    endtask

    initial begin
        clr        = 1'b1;
        load_valid = 1'b0;
        ser_ready  = 1'b0;
        data_in    = '0;

        // Reset held for two edges, then released.
        tick();
        check_idle("reset_1");
        tick();
        clr = 1'b0;
        check_idle("reset_2");
        tick();
        check_idle("post_reset");

        // clr and load_valid on the same edge: the word is dropped.
        clr        = 1'b1;
        load_valid = 1'b1;
        data_in    = 32'hDEAD_BEEF;
        tick();
        clr        = 1'b0;
        load_valid = 1'b0;
        check_idle("clr_load");
        tick();
        check_idle("clr_load_hold");

        ser_ready = 1'b1;

        send_word(32'hA5A5_0F0F, 1'b0, -1, 0, -1, 1'b0, "lsb_pattern");
        send_word(32'h8000_0001, 1'b0, -1, 0, -1, 1'b0, "ends_set");
        send_word(32'hFFFF_0000, 1'b0, 16, 5, -1, 1'b0, "stall16");
        send_word(32'h1234_5678, 1'b0, -1, 0, 10, 1'b0, "abort10");
        send_word(32'h0000_0003, 1'b0, -1, 0, -1, 1'b0, "after_abort");
        send_word(32'hC3A5_9E17, 1'b0, -1, 0, -1, 1'b1, "load_in_shift");

        // Random words with random backpressure and idle gaps.
        for (int n = 0; n < 8; n++) begin
            logic [W-1:0] w;
            int gap;
            w   = $urandom;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                ser_ready = 1'($urandom_range(0, 1));
                data_in   = $urandom;
                tick();
                check_idle($sformatf("gap%0d_%0d", n, g));
            end
            send_word(w, 1'b1, -1, 0, (n == 5) ? int'($urandom_range(0, W - 1)) : -1,
                      1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_serial_out
